// File: rtl/test_monitor.sv
// End-of-test monitor for riscv-tests programs: watches fetches for the halt PC,
// lets in-flight writebacks settle, then reports pass/fail from gp, or a timeout.
module test_monitor #(
  parameter logic [31:0] HALT_PC = 32'h0000_0044,
  parameter logic [31:0] TIMEOUT = 32'd6000,
  parameter int unsigned SETTLE  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic [31:0] gp,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] fail_id,
  output logic [31:0] cycles
);

  typedef enum logic [2:0] {RUN, CHECK, PASS, FAIL, TMO} state_t;

  localparam logic [3:0] SETTLE_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t      state;
  logic [31:0] count;
  logic [3:0]  settle_cnt;
  logic [31:0] count_next;
  logic        hit;
  logic        decide;
  logic        expire;

  // The count saturates so a stuck CHECK or huge TIMEOUT can never wrap it.
  always_comb begin
    hit        = if_valid && (if_pc == HALT_PC);
    count_next = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
    decide     = ((state == RUN) && hit && (SETTLE == 0)) ||
                 ((state == CHECK) && (settle_cnt == 4'd0));
    expire     = (state == RUN) && !hit && (count == TIMEOUT - 32'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      count      <= '0;
      settle_cnt <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      fail_id    <= '0;
      cycles     <= '0;
    end else if (clear) begin
      state      <= RUN;
      count      <= '0;
      settle_cnt <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      fail_id    <= '0;
      cycles     <= '0;
    end else if (decide) begin
      count  <= count_next;
      cycles <= count_next;
      done   <= 1'b1;
      if (gp == 32'h1) begin
        state   <= PASS;
        pass    <= 1'b1;
        fail_id <= '0;
      end else begin
        state   <= FAIL;
        fail    <= 1'b1;
        fail_id <= gp[31:1];
      end
    end else if (expire) begin
      state   <= TMO;
      count   <= count_next;
      cycles  <= count_next;
      done    <= 1'b1;
      timeout <= 1'b1;
      fail_id <= '0;
    end else begin
      case (state)
        RUN: begin
          count <= count_next;
          if (hit) begin
            state      <= CHECK;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        CHECK: begin
          count      <= count_next;
          settle_cnt <= settle_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: two instances (SETTLE=3 and SETTLE=0) share inputs and are
// checked every cycle against a cycle-index model, plus table vectors and corner sequences.
module tb_test_monitor;

  localparam logic [31:0] HALT = 32'h0000_0044;
  localparam logic [31:0] TMO_CYC = 32'd6000;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] gp;

  logic        s3_done, s3_pass, s3_fail, s3_timeout;
  logic [30:0] s3_fail_id;
  logic [31:0] s3_cycles;
  logic        s0_done, s0_pass, s0_fail, s0_timeout;
  logic [30:0] s0_fail_id;
  logic [31:0] s0_cycles;

  int total = 0;
  int bad = 0;

  // Model: per instance, index of the cycle in progress, cycle of the hit, expected outputs.
  logic [31:0] m_n[2];
  logic [31:0] m_hit[2];
  logic [66:0] m_out[2];

  test_monitor #(.HALT_PC(HALT), .TIMEOUT(TMO_CYC), .SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .clear(clear), .if_pc(if_pc), .if_valid(if_valid), .gp(gp),
    .done(s3_done), .pass(s3_pass), .fail(s3_fail), .timeout(s3_timeout),
    .fail_id(s3_fail_id), .cycles(s3_cycles)
  );

  test_monitor #(.HALT_PC(HALT), .TIMEOUT(TMO_CYC), .SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .clear(clear), .if_pc(if_pc), .if_valid(if_valid), .gp(gp),
    .done(s0_done), .pass(s0_pass), .fail(s0_fail), .timeout(s0_timeout),
    .fail_id(s0_fail_id), .cycles(s0_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] pack(input logic d, input logic p, input logic f,
                                       input logic t, input logic [30:0] id,
                                       input logic [31:0] cyc);
    return {d, p, f, t, id, cyc};
  endfunction

  function automatic logic [66:0] act_s3();
    return {s3_done, s3_pass, s3_fail, s3_timeout, s3_fail_id, s3_cycles};
  endfunction

  function automatic logic [66:0] act_s0();
    return {s0_done, s0_pass, s0_fail, s0_timeout, s0_fail_id, s0_cycles};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i]   = 32'd1;
      m_hit[i] = 32'd0;
      m_out[i] = '0;
    end
  endtask

  // Decision happens SETTLE cycles after the hit cycle; timeout on cycle TIMEOUT with no hit.
  task automatic model_step(input logic c);
    logic [31:0] settle;
    for (int i = 0; i < 2; i++) begin
      settle = (i == 0) ? 32'd3 : 32'd0;
      if (c) begin
        m_n[i]   = 32'd1;
        m_hit[i] = 32'd0;
        m_out[i] = '0;
      end else if (!m_out[i][66]) begin
        if (m_hit[i] == 0 && if_valid && if_pc == HALT) m_hit[i] = m_n[i];
        if (m_hit[i] != 0 && m_n[i] == m_hit[i] + settle) begin
          if (gp == 32'h1) m_out[i] = pack(1'b1, 1'b1, 1'b0, 1'b0, 31'd0, m_n[i]);
          else             m_out[i] = pack(1'b1, 1'b0, 1'b1, 1'b0, gp[31:1], m_n[i]);
        end else if (m_hit[i] == 0 && m_n[i] == TMO_CYC) begin
          m_out[i] = pack(1'b1, 1'b0, 1'b0, 1'b1, 31'd0, m_n[i]);
        end
        m_n[i] = m_n[i] + 32'd1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [66:0] act, input logic [66:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] g,
                               input logic c);
    if_valid = v;
    if_pc    = pc;
    gp       = g;
    clear    = c;
    model_step(c);
    @(posedge clk);
    #1;
    checkOutput("model s3", act_s3(), m_out[0]);
    checkOutput("model s0", act_s0(), m_out[1]);
  endtask

  typedef struct {
    int          hit_cyc;
    logic [31:0] gp_val;
    logic        exp_pass;
    logic [30:0] exp_id;
    logic [31:0] exp_cyc_s0;
    logic [31:0] exp_cyc_s3;
  } vec_t;

  vec_t vecs[6];
  logic        rv;
  logic [31:0] rpc;
  logic [31:0] rg;

  initial begin
    vecs[0] = '{5,   32'h0000_0001, 1'b1, 31'd0,          32'd5,   32'd8};
    vecs[1] = '{50,  32'h0000_0007, 1'b0, 31'd3,          32'd50,  32'd53};
    vecs[2] = '{101, 32'h0000_0001, 1'b1, 31'd0,          32'd101, 32'd104};
    vecs[3] = '{1,   32'h0000_0000, 1'b0, 31'd0,          32'd1,   32'd4};
    vecs[4] = '{20,  32'hFFFF_FFFF, 1'b0, 31'h7FFF_FFFF,  32'd20,  32'd23};
    vecs[5] = '{7,   32'h0000_0002, 1'b0, 31'd1,          32'd7,   32'd10};

    rst = 1'b1; clear = 1'b0; if_pc = '0; if_valid = 1'b0; gp = '0;
    model_reset();
    #2;
    checkOutput("reset s3", act_s3(), '0);
    checkOutput("reset s0", act_s0(), '0);
    #1 rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 32'h0, vecs[k].gp_val, 1'b1);
      for (int c = 1; c < vecs[k].hit_cyc; c++)
        applyStimulus(1'b1, 32'h1000 + 32'(c * 4), vecs[k].gp_val, 1'b0);
      for (int c = 0; c < 6; c++) applyStimulus(1'b1, HALT, vecs[k].gp_val, 1'b0);
      checkOutput("vec s0", act_s0(), pack(1'b1, vecs[k].exp_pass, !vecs[k].exp_pass, 1'b0,
                                           vecs[k].exp_id, vecs[k].exp_cyc_s0));
      checkOutput("vec s3", act_s3(), pack(1'b1, vecs[k].exp_pass, !vecs[k].exp_pass, 1'b0,
                                           vecs[k].exp_id, vecs[k].exp_cyc_s3));
    end

    // gp only becomes 1 after the hit: settling instance passes, immediate one fails.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    for (int c = 1; c <= 100; c++) applyStimulus(1'b1, 32'h2000, 32'h0, 1'b0);
    applyStimulus(1'b1, HALT, 32'h0, 1'b0);
    checkOutput("late gp s0", act_s0(), pack(1'b1, 1'b0, 1'b1, 1'b0, 31'd0, 32'd101));
    applyStimulus(1'b1, 32'h3000, 32'h1, 1'b0);
    applyStimulus(1'b1, HALT, 32'h1, 1'b0);
    checkOutput("settle not early", {66'd0, s3_done}, 67'd0);
    applyStimulus(1'b1, 32'h3004, 32'h1, 1'b0);
    checkOutput("late gp s3", act_s3(), pack(1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd104));

    // Timeout, then a later hit must not disturb the result.
    applyStimulus(1'b0, 32'h0, 32'h1, 1'b1);
    for (int c = 1; c <= 6000; c++) applyStimulus(1'b1, 32'h4000, 32'h1, 1'b0);
    checkOutput("timeout s3", act_s3(), pack(1'b1, 1'b0, 1'b0, 1'b1, 31'd0, 32'd6000));
    checkOutput("timeout s0", act_s0(), pack(1'b1, 1'b0, 1'b0, 1'b1, 31'd0, 32'd6000));
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, HALT, 32'h1, 1'b0);
    checkOutput("timeout hold s3", act_s3(), pack(1'b1, 1'b0, 1'b0, 1'b1, 31'd0, 32'd6000));
    checkOutput("timeout hold s0", act_s0(), pack(1'b1, 1'b0, 1'b0, 1'b1, 31'd0, 32'd6000));

    // Hit on the last cycle before timeout wins; CHECK is never timed out.
    applyStimulus(1'b0, 32'h0, 32'h1, 1'b1);
    for (int c = 1; c < 6000; c++) applyStimulus(1'b1, 32'h5000, 32'h1, 1'b0);
    applyStimulus(1'b1, HALT, 32'h1, 1'b0);
    checkOutput("edge hit s0", act_s0(), pack(1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd6000));
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 32'h5004, 32'h1, 1'b0);
    checkOutput("edge hit s3", act_s3(), pack(1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd6003));

    // Halt PC presented without if_valid is not a hit.
    applyStimulus(1'b0, 32'h0, 32'h1, 1'b1);
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, HALT, 32'h1, 1'b0);
    checkOutput("invalid s3", {66'd0, s3_done}, 67'd0);
    checkOutput("invalid s0", {66'd0, s0_done}, 67'd0);

    // Async reset between edges mid-CHECK, then clear from PASS restarts counting at 1.
    applyStimulus(1'b0, 32'h0, 32'h1, 1'b1);
    applyStimulus(1'b1, 32'h200, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'h200, 32'h1, 1'b0);
    applyStimulus(1'b1, HALT, 32'h1, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checkOutput("async rst s3", act_s3(), '0);
    checkOutput("async rst s0", act_s0(), '0);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, HALT, 32'h1, 1'b0);
    checkOutput("after rst s3", act_s3(), pack(1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd4));
    applyStimulus(1'b1, HALT, 32'h1, 1'b1);
    checkOutput("clear s3", act_s3(), '0);
    checkOutput("clear s0", act_s0(), '0);
    applyStimulus(1'b1, HALT, 32'h1, 1'b0);
    checkOutput("restart s0", act_s0(), pack(1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd1));

    // Random traffic with occasional clears.
    for (int r = 0; r < 30; r++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      for (int c = 0; c < int'($urandom_range(200, 20)); c++) begin
        rv  = ($urandom_range(3, 0) != 0);
        rpc = ($urandom_range(29, 0) == 0) ? HALT : ($urandom() & 32'hFFFF_FFFC);
        rg  = ($urandom_range(1, 0) == 1) ? 32'h1 : 32'($urandom_range(15, 0));
        applyStimulus(rv, rpc, rg, ($urandom_range(149, 0) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
